pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: continuous-stall cycles before the hang flag sets; legal range 1..65535.
REQ-002 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port stallreq_if, input, 1 bit: fetch stage cannot accept or deliver an instruction.
REQ-006 SHALL have port stallreq_id, input, 1 bit: decode hazard (load-use).
REQ-007 SHALL have port stallreq_ex, input, 1 bit: execute stage multi-cycle operation busy.
REQ-008 SHALL have port stallreq_mem, input, 1 bit: memory stage access pending.
REQ-009 SHALL have port branch_flag, input, 1 bit: EX resolved a taken branch or jump.
REQ-010 SHALL have port branch_target, input, 32 bits: redirect address.
REQ-011 SHALL have port stall, output, 6 bits: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = hold the producer and bubble the next register.
REQ-012 SHALL have port flush, output, 1 bit: kill the IF/ID and ID/EX contents and load new_pc.
REQ-013 SHALL have port new_pc, output, 32 bits: redirect target, valid only while flush = 1.
REQ-014 SHALL have port stall_timeout, output, 1 bit: sticky hang flag.
REQ-015 SHALL have port stall_cycles, output, CNT_W bits: count of cycles with stall != 0.
REQ-016 SHALL have port flush_count, output, CNT_W bits: count of flush cycles.

Function
REQ-017 SHALL drive stall combinationally, priority mem > ex > id > if: mem gives 6'b011111, ex 6'b001111, id 6'b000111, if 6'b000011, none 6'b000000.
REQ-018 SHALL drive flush = branch_flag & ~stallreq_ex & ~stallreq_mem, combinationally, with no added latency.
REQ-019 SHALL force stall to 6'b000000 while flush = 1; flush overrides stallreq_id and stallreq_if.
REQ-020 SHALL drive new_pc = branch_target while flush = 1, else 32'h0.
REQ-021 SHALL defer a branch that coincides with stallreq_ex or stallreq_mem (flush = 0, stall per REQ-017); EX holds branch_flag, so flush asserts in the first cycle both requests are low.
REQ-022 SHALL implement a registered state machine with states RUN, STALLED and HUNG.
REQ-023 SHALL move RUN -> STALLED at an edge where stall != 0.
REQ-024 SHALL move STALLED -> RUN at an edge where stall == 0.
REQ-025 SHALL move STALLED -> HUNG when the continuous-stall counter reaches TIMEOUT.
REQ-026 SHALL treat HUNG as sticky: left only by reset; stall and flush keep following REQ-017 to REQ-021.
REQ-027 SHALL use a 16-bit continuous-stall counter: it increments each edge with stall != 0, clears to 0 on an edge with stall == 0, and saturates at 16'hFFFF.
REQ-028 SHALL drive stall_timeout = 1 exactly when the state is HUNG (registered).
REQ-029 SHALL increment stall_cycles at each edge with stall != 0, and flush_count at each edge with flush = 1.
REQ-030 SHALL let both performance counters wrap modulo 2^CNT_W.
REQ-031 SHALL make the stall_cycles, flush_count and stall_timeout outputs registered; an event appears in them one cycle after its edge.

Reset
REQ-032 SHALL, on rst low, asynchronously set the state to RUN and clear the continuous-stall counter, stall_cycles, flush_count and stall_timeout to 0.
REQ-033 SHALL keep stall, flush and new_pc combinational during reset: they follow the inputs.
REQ-034 SHALL, on reset asserted mid-stall or while HUNG, clear stall_timeout immediately; after release the counting restarts from 0.
REQ-035 SHALL take no counter increment or state transition on the first edge after reset release if rst is still low at that edge.

Verification
REQ-036 SHALL cover: stallreq_id=1 for 3 cycles -> stall=6'b000111 for 3 cycles, stall_cycles goes 0->3, state RUN->STALLED->RUN.
REQ-037 SHALL cover: stallreq_mem=1, stallreq_if=1 together -> stall=6'b011111.
REQ-038 SHALL cover: branch_flag=1, branch_target=32'h0000_0100, stallreq_id=1 -> flush=1, new_pc=32'h100, stall=0, flush_count +1.
REQ-039 SHALL cover: branch_flag=1 with stallreq_mem=1 for 4 cycles -> flush=0 for those 4 cycles, stall=6'b011111, then flush=1 in cycle 5.
REQ-040 SHALL cover: TIMEOUT=4 with stallreq_ex held for 6 cycles -> stall_timeout rises after the 4th stalled edge and stays 1 after the request drops.
REQ-041 SHALL cover: rst pulsed low while HUNG with stall_cycles=10 -> stall_timeout=0 and stall_cycles=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: prioritised stall vector, branch flush/redirect, hang watchdog, perf counters.
// Latency: stall/flush/new_pc are combinational; stall_timeout and counters are registered (one cycle).
// Backpressure: a stall request freezes the producer stage and everything older; a branch waits out EX/MEM stalls.
module pipe_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             branch_flag,
    input  logic [31:0]      branch_target,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALLED = 2'd1,
        HUNG    = 2'd2
    } state_t;

    localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

    state_t      state;
    logic [15:0] stall_cnt;
    logic [16:0] cnt_inc;
    logic        stalled;
    logic        hit;

    // A resolved branch only wins once EX and MEM are free to accept the redirect.
    always_comb begin
        flush  = branch_flag & ~stallreq_ex & ~stallreq_mem;
        new_pc = flush ? branch_target : 32'h0;
        stall  = 6'b000000;
        if (flush)             stall = 6'b000000;
        else if (stallreq_mem) stall = 6'b011111;
        else if (stallreq_ex)  stall = 6'b001111;
        else if (stallreq_id)  stall = 6'b000111;
        else if (stallreq_if)  stall = 6'b000011;
    end

    assign stalled = |stall;
    assign cnt_inc = (stall_cnt == 16'hFFFF) ? {1'b0, stall_cnt} : {1'b0, stall_cnt} + 17'd1;
    assign hit     = cnt_inc >= TIMEOUT_W;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            stall_cnt     <= 16'h0;
            stall_cycles  <= '0;
            flush_count   <= '0;
            stall_timeout <= 1'b0;
        end else begin
            stall_cnt <= stalled ? cnt_inc[15:0] : 16'h0;
            if (stalled) stall_cycles <= stall_cycles + 1'b1;
            if (flush)   flush_count  <= flush_count + 1'b1;

            case (state)
                RUN: begin
                    if (stalled && hit) begin
                        state         <= HUNG;
                        stall_timeout <= 1'b1;
                    end else if (stalled) begin
                        state <= STALLED;
                    end
                end
                STALLED: begin
                    if (!stalled) begin
                        state <= RUN;
                    end else if (hit) begin
                        state         <= HUNG;
                        stall_timeout <= 1'b1;
                    end
                end
                HUNG: begin
                    state         <= HUNG;
                    stall_timeout <= 1'b1;
                end
                default: begin
                    state         <= RUN;
                    stall_timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule
